// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: shares imem between the boot loader and the fetch engine.
// Optional EBREAK halt/resume is enabled by defining FETCH_CTRL_EBREAK_HALT_EN.
module fetch_ctrl #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BOOT_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              ld_done,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              resume,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       insn,
    output logic [ADDR_W-1:0] insn_pc,
    output logic              insn_valid,
    output logic [1:0]        state
);

    localparam logic [ADDR_W-1:0] BOOT_PC   = ADDR_W'(BOOT_ADDR) & ~ADDR_W'(3);
    localparam logic [31:0]       NOP_INSN  = 32'h0000_0013;
    localparam logic [31:0]       EBRK_INSN = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       insn_q;
    logic [ADDR_W-1:0] insn_pc_q;
    logic              insn_valid_q;

    logic [ADDR_W-1:0] pc_seq_d;
    logic [ADDR_W-1:0] pc_tgt_d;

    // Sequential PC wraps modulo 2^ADDR_W; targets are word-aligned by dropping the low bits.
    assign pc_seq_d = pc_q + ADDR_W'(4);
    assign pc_tgt_d = {redirect_pc[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            pc_q         <= BOOT_PC;
            insn_q       <= NOP_INSN;
            insn_pc_q    <= '0;
            insn_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    insn_valid_q <= 1'b0;
                    if (ld_done) begin
                        state_q <= ST_RUN;
                        pc_q    <= BOOT_PC;
                    end
                end
                ST_RUN: begin
                    if (redirect) begin
                        pc_q         <= pc_tgt_d;
                        insn_valid_q <= 1'b0;
                    end else if (!stall) begin
                        insn_q       <= imem_rdata;
                        insn_pc_q    <= pc_q;
                        insn_valid_q <= 1'b1;
                        pc_q         <= pc_seq_d;
`ifdef FETCH_CTRL_EBREAK_HALT_EN
                        if (imem_rdata == EBRK_INSN) begin
                            state_q <= ST_HALT;
                        end
`endif
                    end
                end
`ifdef FETCH_CTRL_EBREAK_HALT_EN
                ST_HALT: begin
                    insn_valid_q <= 1'b0;
                    if (resume) begin
                        state_q <= ST_RUN;
                    end
                end
`endif
                default: begin
                    state_q      <= ST_LOAD;
                    insn_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        ld_ready   = 1'b0;
        imem_we    = 1'b0;
        imem_addr  = pc_q;
        imem_wdata = '0;
        if (state_q == ST_LOAD) begin
            ld_ready   = 1'b1;
            imem_we    = ld_valid;
            imem_addr  = ld_addr;
            imem_wdata = ld_data;
        end
    end

    assign pc         = pc_q;
    assign insn       = insn_q;
    assign insn_pc    = insn_pc_q;
    assign insn_valid = insn_valid_q;
    assign state      = state_q;

    // Low target bits are discarded by alignment; resume only matters with the halt feature.
    logic unused_in;
`ifdef FETCH_CTRL_EBREAK_HALT_EN
    assign unused_in = ^redirect_pc[1:0];
`else
    assign unused_in = ^{redirect_pc[1:0], resume, EBRK_INSN};
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: driver pushes model predictions, monitor pops and compares.
// Honours FETCH_CTRL_EBREAK_HALT_EN the same way as the design.
module tb_fetch_ctrl;

    localparam logic [31:0] EBRK = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid, ld_ready, ld_done;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    logic        stall, redirect, resume;
    logic [9:0]  redirect_pc;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata, imem_rdata;
    logic [9:0]  pc, insn_pc;
    logic [31:0] insn;
    logic        insn_valid;
    logic [1:0]  state;

    fetch_ctrl #(.ADDR_W(10), .BOOT_ADDR(0)) dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_done(ld_done), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .resume(resume), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_rdata(imem_rdata), .pc(pc), .insn(insn), .insn_pc(insn_pc),
        .insn_valid(insn_valid), .state(state)
    );

    always #5 clk = ~clk;

    // Instruction memory seen by the DUT
    logic [31:0] mem [256];
    assign imem_rdata = mem[imem_addr[9:2]];
    always @(posedge clk) if (imem_we) mem[imem_addr[9:2]] <= imem_wdata;

    // Reference model state
    logic [31:0] ref_mem [256];
    int          m_state;
    int unsigned m_pc, m_ipc;
    logic [31:0] m_insn;
    logic        m_iv;

    typedef struct {
        logic [1:0]  st;
        logic [9:0]  pc;
        logic [31:0] insn;
        logic [9:0]  ipc;
        logic        iv;
        logic        ldr;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wd;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    task automatic step(input logic rst, input logic ldv, input logic [9:0] lda,
                        input logic [31:0] ldd, input logic done, input logic stl,
                        input logic rdr, input logic [9:0] rpc, input logic rsm);
        exp_t e;
        logic [31:0] w;
        @(negedge clk);
        reset = rst; ld_valid = ldv; ld_addr = lda; ld_data = ldd; ld_done = done;
        stall = stl; redirect = rdr; redirect_pc = rpc; resume = rsm;
        if (rst) begin
            m_state = 0; m_pc = 0; m_insn = 32'h13; m_ipc = 0; m_iv = 1'b0;
        end else begin
            case (m_state)
                0: begin
                    if (ldv) ref_mem[lda / 4] = ldd;
                    m_iv = 1'b0;
                    if (done) begin m_state = 1; m_pc = 0; end
                end
                1: begin
                    if (rdr) begin
                        m_pc = rpc - (rpc % 4);
                        m_iv = 1'b0;
                    end else if (!stl) begin
                        w = ref_mem[m_pc / 4];
                        m_insn = w; m_ipc = m_pc; m_iv = 1'b1;
                        m_pc = (m_pc + 4) % 1024;
`ifdef FETCH_CTRL_EBREAK_HALT_EN
                        if (w == EBRK) m_state = 2;
`endif
                    end
                end
                default: begin
                    m_iv = 1'b0;
                    if (rsm) m_state = 1;
                end
            endcase
        end
        e.st = 2'(m_state); e.pc = 10'(m_pc); e.insn = m_insn; e.ipc = 10'(m_ipc); e.iv = m_iv;
        e.ldr = (m_state == 0); e.we = (m_state == 0) && ldv;
        e.addr = (m_state == 0) ? lda : 10'(m_pc);
        e.wd = ldd;
        q.push_back(e);
    endtask

    // Run-phase step: loader pins carry random traffic that must be ignored outside LOAD
    task automatic go(input logic stl, input logic rdr, input logic [9:0] rpc, input logic rsm);
        step(1'b0, 1'($urandom), 10'($urandom), $urandom, 1'b0, stl, rdr, rpc, rsm);
    endtask

    task automatic idle_load();
        step(1'b0, 1'b0, 10'($urandom), $urandom, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
    endtask

    // Monitor: compares DUT state just after each rising edge against the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state", 32'(state), 32'(e.st));
                chk("pc", 32'(pc), 32'(e.pc));
                chk("insn_valid", 32'(insn_valid), 32'(e.iv));
                if (e.iv) begin
                    chk("insn", insn, e.insn);
                    chk("insn_pc", 32'(insn_pc), 32'(e.ipc));
                end else if (e.st == 2'b00) begin
                    chk("insn_rst", insn, e.insn);
                    chk("insn_pc_rst", 32'(insn_pc), 32'(e.ipc));
                end
                chk("ld_ready", 32'(ld_ready), 32'(e.ldr));
                chk("imem_we", 32'(imem_we), 32'(e.we));
                chk("imem_addr", 32'(imem_addr), 32'(e.addr));
                if (e.ldr) chk("imem_wdata", imem_wdata, e.wd);
            end
        end
    end

    initial begin
        logic [31:0] w;
        for (int unsigned i = 0; i < 256; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        reset = 1'b1; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = '0; resume = 1'b0;
        m_state = 0; m_pc = 0; m_insn = 32'h13; m_ipc = 0; m_iv = 1'b0;

        repeat (2) step(1'b1, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);

        // Load all 256 words; the last write coincides with ld_done
        for (int unsigned i = 0; i < 256; i++) begin
            if ($urandom_range(0, 3) == 0) idle_load();
            case (i)
                0: w = 32'h0050_0093;
                1: w = 32'h0010_0113;
                2: w = 32'h0000_0013;
                8: w = EBRK;
                default: begin
                    w = $urandom;
                    if (w == EBRK) w = 32'h13;
                end
            endcase
            step(1'b0, 1'b1, 10'(i * 4), w, (i == 255), 1'b0, 1'b0, 10'd0, 1'b0);
        end

        // Straight-line fetch up to and past the EBREAK at 0x20
        repeat (10) go(1'b0, 1'b0, 10'd0, 1'b0);
        repeat (3) go(1'b1, 1'b1, 10'h3F0, 1'b0);
        go(1'b0, 1'b0, 10'd0, 1'b1);
        repeat (3) go(1'b0, 1'b0, 10'd0, 1'b0);

        // Redirect to 0x010, then to 0x0A6 while at 0x010
        go(1'b0, 1'b1, 10'h010, 1'b0);
        go(1'b0, 1'b1, 10'h0A6, 1'b0);
        repeat (2) go(1'b0, 1'b0, 10'd0, 1'b0);

        // Stall hold, then redirect together with stall
        repeat (3) go(1'b1, 1'b0, 10'd0, 1'b0);
        go(1'b1, 1'b1, 10'h155, 1'b0);
        repeat (2) go(1'b0, 1'b0, 10'd0, 1'b0);

        // PC wrap 1016 -> 1020 -> 0 -> 4
        go(1'b0, 1'b1, 10'd1016, 1'b0);
        repeat (4) go(1'b0, 1'b0, 10'd0, 1'b0);

        // Random traffic
        for (int unsigned n = 0; n < 3000; n++) begin
            go(($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0),
               ($urandom_range(0, 3) == 0) ? 10'h020 : 10'($urandom),
               ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of operation, partial reload, separate ld_done pulse
        repeat (2) step(1'b1, 1'b0, 10'd0, 32'd0, 1'b0, 1'b1, 1'b1, 10'h100, 1'b1);
        for (int unsigned i = 0; i < 4; i++) begin
            w = $urandom;
            if (w == EBRK) w = 32'h13;
            step(1'b0, 1'b1, 10'(i * 4 + $urandom_range(0, 3)), w, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
        end
        idle_load();
        step(1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 10'd0, 1'b0);
        repeat (8) go(1'b0, 1'b0, 10'd0, 1'b0);
        repeat (2) go(1'b1, 1'b0, 10'd0, 1'b0);

        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        for (int unsigned i = 0; i < 256; i++) chk("mem_contents", mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
